// File: rtl/alu_stage.sv
// alu_stage: execute stage. Single-cycle integer ops are registered on the
// next edge. mult/div use a 32-step iterative engine that stalls upstream.
module alu_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_in,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] wdata_in,
  output logic [31:0] result,
  output logic [31:0] wdata_out,
  output logic [31:0] instruction_out,
  output logic        overflow,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;        // multiply: running high word; divide: remainder
  logic [31:0] work_q, work_d;      // multiply: multiplier/low word; divide: dividend/quotient
  logic [31:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
  logic        neg_q, neg_d;        // negate product/quotient at the end
  logic        neg_rem_q, neg_rem_d;
  logic        is_div_q, is_div_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] dvd_raw_q, dvd_raw_d;
  logic [31:0] held_q, held_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] result_q, result_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] instr_q, instr_d;
  logic        ovf_q, ovf_d;

  // Decode
  logic [5:0] op, func;
  logic       is_r, is_mult, is_multu, is_div, is_divu, is_md, md_signed;
  assign op        = instruction_in[31:26];
  assign func      = instruction_in[5:0];
  assign is_r      = (op == 6'b000000);
  assign is_mult   = is_r && (func == 6'b011000);
  assign is_multu  = is_r && (func == 6'b011001);
  assign is_div    = is_r && (func == 6'b011010);
  assign is_divu   = is_r && (func == 6'b011011);
  assign is_md     = is_mult || is_multu || is_div || is_divu;
  assign md_signed = is_mult || is_div;

  logic [31:0] alu_res, sum, diff;
  logic        alu_ovf;

  // Single-cycle ALU result and signed-overflow flag
  always_comb begin
    alu_res = 32'h0;
    alu_ovf = 1'b0;
    sum     = A + B;
    diff    = A - B;
    if (is_r) begin
      case (func)
        6'b100000: begin alu_res = sum;  alu_ovf = (A[31] == B[31]) && (sum[31] != A[31]); end
        6'b100001: alu_res = sum;
        6'b100010: begin alu_res = diff; alu_ovf = (A[31] != B[31]) && (diff[31] != A[31]); end
        6'b100011: alu_res = diff;
        6'b100110: alu_res = A ^ B;
        6'b000000: alu_res = B << instruction_in[10:6];
        6'b010000: alu_res = hi_q;
        6'b010010: alu_res = lo_q;
        default:   alu_res = 32'h0;
      endcase
    end else begin
      case (op)
        6'b001000: begin alu_res = sum; alu_ovf = (A[31] == B[31]) && (sum[31] != A[31]); end
        6'b001111: alu_res = {B[15:0], 16'h0000};
        6'b100011: alu_res = sum;
        6'b101011: alu_res = sum;
        default:   alu_res = 32'h0;
      endcase
    end
  end

  logic [32:0] mul_sum, div_shift, div_diff;
  logic [31:0] acc_step, work_step, hi_fin, lo_fin;
  logic [63:0] prod, prod_neg;

  // One shift-add / restoring-subtract step plus final sign correction
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift = {acc_q, work_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      // No borrow out of bit 32 means the shifted remainder covers the divisor
      if (!div_diff[32]) begin
        acc_step  = div_diff[31:0];
        work_step = {work_q[30:0], 1'b1};
      end else begin
        acc_step  = div_shift[31:0];
        work_step = {work_q[30:0], 1'b0};
      end
    end else begin
      acc_step  = mul_sum[32:1];
      work_step = {mul_sum[0], work_q[31:1]};
    end
    prod     = {acc_step, work_step};
    prod_neg = 64'd0 - prod;
    if (is_div_q) begin
      lo_fin = neg_q ? (32'd0 - work_step) : work_step;
      hi_fin = neg_rem_q ? (32'd0 - acc_step) : acc_step;
      if (div_zero_q) begin
        lo_fin = 32'hFFFFFFFF;
        hi_fin = dvd_raw_q;
      end
    end else begin
      {hi_fin, lo_fin} = neg_q ? prod_neg : prod;
    end
  end

  // Mult/div FSM next state, stall and output-register next values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    work_d     = work_q;
    opnd_d     = opnd_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    dvd_raw_d  = dvd_raw_q;
    held_d     = held_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    result_d   = alu_res;
    wdata_d    = wdata_in;
    instr_d    = instruction_in;
    ovf_d      = alu_ovf;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_md) begin
          stall      = 1'b1;
          result_d   = 32'h0;
          wdata_d    = 32'h0;
          instr_d    = 32'h0;
          ovf_d      = 1'b0;
          cnt_d      = 5'd0;
          acc_d      = 32'h0;
          work_d     = (md_signed && A[31]) ? (32'd0 - A) : A;
          opnd_d     = (md_signed && B[31]) ? (32'd0 - B) : B;
          neg_d      = md_signed && (A[31] ^ B[31]);
          neg_rem_d  = md_signed && A[31];
          is_div_d   = is_div || is_divu;
          div_zero_d = (B == 32'h0);
          dvd_raw_d  = A;
          held_d     = instruction_in;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        stall    = 1'b1;
        result_d = 32'h0;
        wdata_d  = 32'h0;
        instr_d  = 32'h0;
        ovf_d    = 1'b0;
        acc_d    = acc_step;
        work_d   = work_step;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          hi_d    = hi_fin;
          lo_d    = lo_fin;
          state_d = DONE;
        end
      end
      DONE: begin
        instr_d  = held_q;
        result_d = 32'h0;
        ovf_d    = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      acc_q      <= 32'h0;
      work_q     <= 32'h0;
      opnd_q     <= 32'h0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      dvd_raw_q  <= 32'h0;
      held_q     <= 32'h0;
      hi_q       <= 32'h0;
      lo_q       <= 32'h0;
      result_q   <= 32'h0;
      wdata_q    <= 32'h0;
      instr_q    <= 32'h0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      work_q     <= work_d;
      opnd_q     <= opnd_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      dvd_raw_q  <= dvd_raw_d;
      held_q     <= held_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      result_q   <= result_d;
      wdata_q    <= wdata_d;
      instr_q    <= instr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign result          = result_q;
  assign wdata_out       = wdata_q;
  assign instruction_out = instr_q;
  assign overflow        = ovf_q;

endmodule
